// File: rtl/counter_step_ctrl.sv
// Command sequencer for the shared up/down counter: accepts GOTO/SWEEP commands,
// emits paced single-cycle step pulses with direction, and reports completion or abort.
module counter_step_ctrl #(
    parameter int WIDTH    = 4,
    parameter int STEP_GAP = 2,
    parameter int REP_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             step_en,
    output logic             up_dn,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int TW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL   = 3'd1,
        S_STEP   = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic             cmd_ready_reg, cmd_ready_next;
    logic             step_en_reg, step_en_next;
    logic             up_dn_reg, up_dn_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             aborted_reg, aborted_next;

    logic             mode_reg;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] goal_reg;
    logic [REP_W-1:0] reps_reg;
    logic [REP_W-1:0] rep_cnt_reg;
    logic             phase_up_reg;
    logic [TW-1:0]    wait_cnt_reg;

    logic             accept;
    logic             abort_take;
    logic             at_goal;
    logic             wait_last;
    logic             last_rep;
    logic [REP_W:0]   rep_inc;
    logic [REP_W:0]   reps_eff;

    assign accept     = cmd_valid && cmd_ready_reg;
    assign abort_take = abort && ((state_reg == S_EVAL) || (state_reg == S_STEP) ||
                                  (state_reg == S_WAIT));
    assign at_goal    = (cnt_q == goal_reg);
    assign wait_last  = (wait_cnt_reg == TW'(STEP_GAP - 1));
    assign rep_inc    = (REP_W+1)'(rep_cnt_reg) + (REP_W+1)'(1);
    // A repetition count of zero still runs one up/down pass
    assign reps_eff   = (reps_reg == '0) ? (REP_W+1)'(1) : (REP_W+1)'(reps_reg);
    assign last_rep   = (rep_inc >= reps_eff);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            cmd_ready_reg <= 1'b1;
            step_en_reg   <= 1'b0;
            up_dn_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            step_en_reg   <= step_en_next;
            up_dn_reg     <= up_dn_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            aborted_reg   <= aborted_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) state_next = S_EVAL;
            end
            S_EVAL: begin
                // Abort wins over whatever the compare would have decided
                if (abort)              state_next = S_FINISH;
                else if (!at_goal)      state_next = S_STEP;
                else if (!mode_reg)     state_next = S_FINISH;
                else if (phase_up_reg)  state_next = S_EVAL;
                else if (last_rep)      state_next = S_FINISH;
                else                    state_next = S_EVAL;
            end
            S_STEP: begin
                state_next = abort ? S_FINISH : S_WAIT;
            end
            S_WAIT: begin
                if (abort)          state_next = S_FINISH;
                else if (wait_last) state_next = S_EVAL;
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready_next = (state_next == S_IDLE);
        busy_next      = (state_next == S_EVAL) || (state_next == S_STEP) ||
                         (state_next == S_WAIT);
        step_en_next   = (state_next == S_STEP);
        done_next      = (state_next == S_FINISH);
        up_dn_next     = up_dn_reg;
        if ((state_reg == S_EVAL) && (state_next == S_STEP)) up_dn_next = (cnt_q < goal_reg);
        aborted_next   = aborted_reg;
        if (accept)          aborted_next = 1'b0;
        else if (abort_take) aborted_next = 1'b1;
    end

    // Command latch, sweep phase/goal bookkeeping and inter-step timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg     <= 1'b0;
            target_reg   <= '0;
            goal_reg     <= '0;
            reps_reg     <= '0;
            rep_cnt_reg  <= '0;
            phase_up_reg <= 1'b1;
            wait_cnt_reg <= '0;
        end else begin
            if (accept) begin
                mode_reg     <= cmd_mode;
                target_reg   <= cmd_target;
                goal_reg     <= cmd_target;
                reps_reg     <= cmd_reps;
                rep_cnt_reg  <= '0;
                phase_up_reg <= 1'b1;
            end else if ((state_reg == S_EVAL) && !abort && at_goal && mode_reg) begin
                if (phase_up_reg) begin
                    goal_reg     <= '0;
                    phase_up_reg <= 1'b0;
                end else begin
                    rep_cnt_reg <= rep_inc[REP_W-1:0];
                    if (!last_rep) begin
                        goal_reg     <= target_reg;
                        phase_up_reg <= 1'b1;
                    end
                end
            end
            if (state_reg == S_STEP)      wait_cnt_reg <= '0;
            else if (state_reg == S_WAIT) wait_cnt_reg <= wait_cnt_reg + TW'(1);
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign step_en   = step_en_reg;
    assign up_dn     = up_dn_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Bench for counter_step_ctrl: a behavioural counter plus a goal-list model that
// predicts every step pulse (cycle, direction), the done cycle and the final count.
module tb_counter_step_ctrl;
    localparam int GAP   = 2;
    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_mode = 1'b0;
    logic [3:0] cmd_target = '0;
    logic [3:0] cmd_reps = '0;
    logic       abort = 1'b0;
    logic [3:0] cnt = '0;
    logic       step_en, up_dn, busy, done, aborted;
    logic       load_en = 1'b0;
    logic [3:0] load_val = '0;

    int checks = 0;
    int failures = 0;

    int obs_t[$];
    bit obs_d[$];
    int exp_t[$];
    bit exp_d[$];
    int obs_done, exp_done, exp_final, bz_err;
    bit done_busy, done_ready, done_aborted, after_done, after_ready;

    counter_step_ctrl #(.WIDTH(4), .STEP_GAP(GAP), .REP_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_target(cmd_target), .cmd_reps(cmd_reps),
        .abort(abort), .cnt_q(cnt), .step_en(step_en), .up_dn(up_dn),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // The counter being driven
    always @(posedge clk) begin
        if (load_en)      cnt <= load_val;
        else if (step_en) cnt <= up_dn ? cnt + 4'd1 : cnt - 4'd1;
    end

    task automatic load_cnt(input int v);
        load_val = 4'(v);
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Edge numbers are counted from the accept edge (0)
    task automatic model_cmd(input bit mode, input int target, input int reps,
                             input int start, input int abort_at);
        int goals[$];
        int cur, e, sum;
        exp_t.delete(); exp_d.delete();
        if (!mode) goals.push_back(target);
        else for (int r = 0; r < ((reps == 0) ? 1 : reps); r++) begin
            goals.push_back(target); goals.push_back(0);
        end
        cur = start; e = 0;
        foreach (goals[g]) begin
            while (cur != goals[g]) begin
                exp_t.push_back(e + 1);
                exp_d.push_back(cur < goals[g]);
                cur += (cur < goals[g]) ? 1 : -1;
                e += GAP + 2;
            end
            e += 1;
        end
        exp_done = e; exp_final = cur;
        if (abort_at >= 0 && abort_at + 1 < e) begin
            while (exp_t.size() > 0 && exp_t[$] > abort_at) begin
                void'(exp_t.pop_back()); void'(exp_d.pop_back());
            end
            sum = start;
            foreach (exp_d[i]) sum += exp_d[i] ? 1 : -1;
            exp_done = abort_at + 1; exp_final = sum;
        end
    endtask

    task automatic run_cmd(input bit mode, input int target, input int reps,
                           input int abort_at, input bit junk);
        int start = int'(cnt);
        obs_t.delete(); obs_d.delete();
        obs_done = -1; bz_err = 0;
        cmd_mode = mode; cmd_target = 4'(target); cmd_reps = 4'(reps); cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (junk) begin
            cmd_mode = ~mode; cmd_target = ~cmd_target; cmd_reps = cmd_reps + 4'd1;
        end else cmd_valid = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            abort = (k - 1 == abort_at);
            @(posedge clk); #1;
            if (step_en) begin obs_t.push_back(k); obs_d.push_back(up_dn); end
            if (done) begin
                obs_done = k; done_busy = busy; done_ready = cmd_ready; done_aborted = aborted;
                cmd_valid = 1'b0; abort = 1'b0;
                @(posedge clk); #1;
                after_done = done; after_ready = cmd_ready;
                break;
            end else if (busy !== 1'b1 || cmd_ready !== 1'b0) bz_err++;
        end
        abort = 1'b0; cmd_valid = 1'b0;
        $display("cmd mode=%0d target=%0d reps=%0d start=%0d abort_at=%0d pulses=%0d done_at=%0d cnt=%0d",
                 mode, target, reps, start, abort_at, obs_t.size(), obs_done, cnt);
    endtask

    function automatic int seq_diff();
        int n = (obs_t.size() < exp_t.size()) ? obs_t.size() : exp_t.size();
        for (int i = 0; i < n; i++)
            if (obs_t[i] != exp_t[i] || obs_d[i] != exp_d[i]) return i;
        return (obs_t.size() == exp_t.size()) ? -1 : n;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        checks++; if ({cmd_ready, step_en, up_dn, busy, done, aborted} !== 6'b101000) begin
            failures++; $display("FAIL reset_idle got=%b exp=101000", {cmd_ready, step_en, up_dn, busy, done, aborted}); end
        load_cnt(0);
        cmd_mode = 1'b1; cmd_target = 4'd5; cmd_reps = 4'd2; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_pre_busy got=%b exp=1", busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({cmd_ready, step_en, up_dn, busy, done, aborted} !== 6'b101000) begin
            failures++; $display("FAIL reset_async got=%b exp=101000", {cmd_ready, step_en, up_dn, busy, done, aborted}); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({cmd_ready, busy, step_en} !== 3'b100) begin
            failures++; $display("FAIL reset_after got=%b exp=100", {cmd_ready, busy, step_en}); end
    endtask

    task automatic test_goto_up();
        load_cnt(0); model_cmd(0, 9, 0, 0, -1); run_cmd(0, 9, 0, -1, 0);
        checks++; if (obs_t.size() != 9) begin failures++; $display("FAIL goto_up_pulses got=%0d exp=9", obs_t.size()); end
        checks++; if (seq_diff() != -1) begin failures++; $display("FAIL goto_up_seq first_diff=%0d exp=-1", seq_diff()); end
        checks++; if (obs_done != exp_done) begin failures++; $display("FAIL goto_up_done got=%0d exp=%0d", obs_done, exp_done); end
        checks++; if (cnt !== 4'd9) begin failures++; $display("FAIL goto_up_cnt got=%0d exp=9", cnt); end
    endtask

    task automatic test_goto_down();
        load_cnt(9); model_cmd(0, 3, 0, 9, -1); run_cmd(0, 3, 0, -1, 1);
        checks++; if (obs_t.size() != 6) begin failures++; $display("FAIL goto_dn_pulses got=%0d exp=6", obs_t.size()); end
        checks++; if (seq_diff() != -1) begin failures++; $display("FAIL goto_dn_seq first_diff=%0d exp=-1", seq_diff()); end
        checks++; if (obs_done != exp_done) begin failures++; $display("FAIL goto_dn_done got=%0d exp=%0d", obs_done, exp_done); end
        checks++; if ({done_busy, done_ready, after_done, after_ready, done_aborted} !== 5'b00010 || bz_err != 0) begin
            failures++; $display("FAIL goto_dn_hs got=%b bz_err=%0d exp=00010/0",
                                 {done_busy, done_ready, after_done, after_ready, done_aborted}, bz_err); end
        checks++; if (cnt !== 4'd3) begin failures++; $display("FAIL goto_dn_cnt got=%0d exp=3", cnt); end
    endtask

    task automatic test_sweep();
        load_cnt(0); model_cmd(1, 5, 2, 0, -1); run_cmd(1, 5, 2, -1, 0);
        checks++; if (obs_t.size() != 20) begin failures++; $display("FAIL sweep_pulses got=%0d exp=20", obs_t.size()); end
        checks++; if (seq_diff() != -1) begin failures++; $display("FAIL sweep_seq first_diff=%0d exp=-1", seq_diff()); end
        checks++; if (obs_done != exp_done) begin failures++; $display("FAIL sweep_done got=%0d exp=%0d", obs_done, exp_done); end
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL sweep_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_at_target();
        load_cnt(7); run_cmd(0, 7, 0, -1, 0);
        checks++; if (obs_t.size() != 0) begin failures++; $display("FAIL at_target_pulses got=%0d exp=0", obs_t.size()); end
        checks++; if (obs_done != 1) begin failures++; $display("FAIL at_target_done got=%0d exp=1", obs_done); end
        load_cnt(0); model_cmd(1, 3, 0, 0, -1); run_cmd(1, 3, 0, -1, 0);
        checks++; if (obs_t.size() != 6) begin failures++; $display("FAIL reps0_pulses got=%0d exp=6", obs_t.size()); end
        checks++; if (obs_done != exp_done) begin failures++; $display("FAIL reps0_done got=%0d exp=%0d", obs_done, exp_done); end
    endtask

    task automatic test_abort();
        int ab;
        load_cnt(0); model_cmd(1, 6, 2, 0, -1);
        ab = exp_t[2] + 1;
        model_cmd(1, 6, 2, 0, ab); run_cmd(1, 6, 2, ab, 1);
        checks++; if (seq_diff() != -1) begin failures++; $display("FAIL abort_seq first_diff=%0d exp=-1", seq_diff()); end
        checks++; if (obs_done != ab + 1) begin failures++; $display("FAIL abort_done got=%0d exp=%0d", obs_done, ab + 1); end
        checks++; if (cnt !== 4'd3) begin failures++; $display("FAIL abort_cnt got=%0d exp=3", cnt); end
        checks++; if (done_aborted !== 1'b1) begin failures++; $display("FAIL abort_flag got=%b exp=1", done_aborted); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({aborted, step_en, cmd_ready} !== 3'b101) begin
            failures++; $display("FAIL abort_hold got=%b exp=101", {aborted, step_en, cmd_ready}); end
        run_cmd(0, 3, 0, -1, 0);
        checks++; if (done_aborted !== 1'b0) begin failures++; $display("FAIL abort_clear got=%b exp=0", done_aborted); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int st  = int'($urandom_range(0, 15));
            int tg  = int'($urandom_range(0, 15));
            int rp  = int'($urandom_range(0, 3));
            bit md  = 1'($urandom_range(0, 1));
            int ab  = -1;
            load_cnt(st);
            model_cmd(md, tg, rp, st, -1);
            if (exp_done >= 3 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, exp_done - 2));
            model_cmd(md, tg, rp, st, ab);
            run_cmd(md, tg, rp, ab, 1'($urandom_range(0, 1)));
            checks++; if (seq_diff() != -1) begin
                failures++; $display("FAIL rand%0d_seq first_diff=%0d got_n=%0d exp_n=%0d", n, seq_diff(), obs_t.size(), exp_t.size()); end
            checks++; if (obs_done != exp_done || cnt !== 4'(exp_final)) begin
                failures++; $display("FAIL rand%0d_end done=%0d cnt=%0d exp done=%0d cnt=%0d", n, obs_done, cnt, exp_done, exp_final); end
            checks++; if ({done_busy, done_ready, after_done, after_ready, done_aborted} !== {4'b0001, ab >= 0} || bz_err != 0) begin
                failures++; $display("FAIL rand%0d_hs got=%b bz_err=%0d exp=%b/0", n,
                                     {done_busy, done_ready, after_done, after_ready, done_aborted}, bz_err, {4'b0001, ab >= 0}); end
        end
    endtask

    initial begin
        test_reset();
        test_goto_up();
        test_goto_down();
        test_sweep();
        test_at_target();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
